// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-first priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  input  logic [DATA_W/8-1:0]   d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  busy_o
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t              state;
  logic [3:0]          lat_cnt;
  logic                owner_d;
  logic                busy_reg;
  logic                if_rvalid_reg;
  logic                d_rvalid_reg;
  logic [DATA_W-1:0]   if_rdata_reg;
  logic [DATA_W-1:0]   d_rdata_reg;

  logic                arb_idle;
  logic                data_wins;
  logic                d_win;
  logic                if_win;
  logic                rd_grant;

`ifdef MEM_ARB_RR_EN
  logic last_gnt_d;  // 1 = data port was granted last
  assign data_wins = !last_gnt_d;
`else
  assign data_wins = 1'b1;
`endif

  // Grants are gated by rst so nothing is accepted while reset is held.
  assign arb_idle = (state == IDLE) && !rst;
  assign d_win    = arb_idle && d_req_i && (!if_req_i || data_wins);
  assign if_win   = arb_idle && if_req_i && !d_win;
  assign rd_grant = if_win || (d_win && !d_we_i);

  assign if_gnt_o    = if_win;
  assign d_gnt_o     = d_win;
  assign mem_req_o   = if_win || d_win;
  assign mem_we_o    = d_win && d_we_i;
  assign mem_addr_o  = d_win ? d_addr_i : if_addr_i;
  assign mem_wdata_o = d_wdata_i;
  assign mem_be_o    = d_win ? d_be_i : {BE_W{1'b1}};

  assign if_rvalid_o = if_rvalid_reg;
  assign if_rdata_o  = if_rdata_reg;
  assign d_rvalid_o  = d_rvalid_reg;
  assign d_rdata_o   = d_rdata_reg;
  assign busy_o      = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= 4'd0;
      owner_d       <= 1'b0;
      busy_reg      <= 1'b0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
`ifdef MEM_ARB_RR_EN
      last_gnt_d    <= 1'b0;
`endif
    end else begin
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      if (if_win || d_win) begin
        last_gnt_d <= d_win;
      end
`endif
      if (state == IDLE) begin
        if (rd_grant) begin
          owner_d  <= d_win;
          lat_cnt  <= 4'd0;
          busy_reg <= 1'b1;
          state    <= RD_WAIT;
        end
      end else begin
        lat_cnt <= lat_cnt + 4'd1;
        // Memory data is valid this cycle; rvalid follows one cycle later.
        if (lat_cnt == LAT_LAST) begin
          if (owner_d) begin
            d_rdata_reg  <= mem_rdata_i;
            d_rvalid_reg <= 1'b1;
          end else begin
            if_rdata_reg  <= mem_rdata_i;
            if_rvalid_reg <= 1'b1;
          end
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// cycle-count reference model and a latency-modelled memory.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  function automatic logic [31:0] init_val(int i);
    return (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0011_1111;
  endfunction

  // Memory with LAT-cycle read latency; junk on the bus outside valid cycles.
  logic           mem_init;
  logic [31:0]    env_mem [16];
  logic [31:0]    pipe_d  [LAT];
  logic [LAT-1:0] pipe_v;
  logic [31:0]    junk;

  assign mem_rdata_i = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

  always @(posedge clk) begin : env_memory
    logic [31:0] w;
    junk <= $urandom;
    if (mem_init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
      pipe_v <= '0;
    end else begin
      if (mem_req_o && mem_we_o) begin
        w = env_mem[mem_addr_o[5:2]];
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        env_mem[mem_addr_o[5:2]] <= w;
      end
      pipe_v[0] <= mem_req_o && !mem_we_o;
      pipe_d[0] <= env_mem[mem_addr_o[5:2]];
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

  // Reference model state: cycle numbers of availability and pending returns.
  int          checks = 0;
  int          errors = 0;
  int          cyc, ready_cyc, if_rv_at, d_rv_at;
  logic        last_d;
  logic [31:0] if_pend, d_pend, exp_if_rdata, exp_d_rdata;
  logic [31:0] ref_mem [16];
  logic        g_if, g_d, s_d_rvalid, s_if_gnt, s_d_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ready_cyc    = cyc;
    if_rv_at     = -1;
    d_rv_at      = -1;
    last_d       = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
  endtask

  // One clock cycle: inputs are already driven; check at negedge, then advance.
  task automatic step();
    logic can, wins, eg_if, eg_d, ev_if, ev_d;
    @(negedge clk);
    can = (cyc >= ready_cyc);
`ifdef MEM_ARB_RR_EN
    wins = !last_d;
`else
    wins = 1'b1;
`endif
    eg_d  = can && d_req_i && (!if_req_i || wins);
    eg_if = can && if_req_i && !eg_d;
    ev_if = (if_rv_at == cyc);
    ev_d  = (d_rv_at == cyc);
    if (ev_if) exp_if_rdata = if_pend;
    if (ev_d)  exp_d_rdata  = d_pend;

    chkb("if_gnt", if_gnt_o, eg_if);
    chkb("d_gnt", d_gnt_o, eg_d);
    chkb("mem_req", mem_req_o, eg_if || eg_d);
    chkb("mem_we", mem_we_o, eg_d && d_we_i);
    if (eg_d) begin
      chk("mem_addr_d", mem_addr_o, d_addr_i);
      if (d_we_i) begin
        chk("mem_wdata", mem_wdata_o, d_wdata_i);
        chk("mem_be_d", 32'(mem_be_o), 32'(d_be_i));
      end
    end
    if (eg_if) begin
      chk("mem_addr_f", mem_addr_o, if_addr_i);
      chk("mem_be_f", 32'(mem_be_o), 32'hF);
    end
    chkb("busy", busy_o, !can);
    chkb("if_rvalid", if_rvalid_o, ev_if);
    chkb("d_rvalid", d_rvalid_o, ev_d);
    chk("if_rdata", if_rdata_o, exp_if_rdata);
    chk("d_rdata", d_rdata_o, exp_d_rdata);

    s_d_rvalid = d_rvalid_o;
    s_if_gnt   = if_gnt_o;
    s_d_gnt    = d_gnt_o;
    g_if       = eg_if;
    g_d        = eg_d;

    if (eg_d && d_we_i) begin
      for (int b = 0; b < 4; b++)
        if (d_be_i[b]) ref_mem[d_addr_i[5:2]][8*b +: 8] = d_wdata_i[8*b +: 8];
    end else if (eg_d) begin
      ready_cyc = cyc + LAT + 1;
      d_rv_at   = ready_cyc;
      d_pend    = ref_mem[d_addr_i[5:2]];
    end
    if (eg_if) begin
      ready_cyc = cyc + LAT + 1;
      if_rv_at  = ready_cyc;
      if_pend   = ref_mem[if_addr_i[5:2]];
    end
    if (eg_if || eg_d) last_d = eg_d;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nd, nf;
    rst = 1'b1; mem_init = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h0; d_req_i = 1'b1; d_we_i = 1'b0;
    d_addr_i = 32'h0; d_wdata_i = 32'h0; d_be_i = 4'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    cyc = 0;
    model_reset();

    // Reset state, with both requests asserted to show grants are held off.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkb("rst_if_gnt", if_gnt_o, 1'b0);
    chkb("rst_d_gnt", d_gnt_o, 1'b0);
    chkb("rst_mem_req", mem_req_o, 1'b0);
    chkb("rst_mem_we", mem_we_o, 1'b0);
    chkb("rst_busy", busy_o, 1'b0);
    chkb("rst_if_rvalid", if_rvalid_o, 1'b0);
    chkb("rst_d_rvalid", d_rvalid_o, 1'b0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_d_rdata", d_rdata_o, 32'h0);
    if_req_i = 1'b0; d_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0;

    // Fetch read of 0x100 (memory word holds 0xDEADBEEF).
    if_req_i = 1'b1; if_addr_i = 32'h100;
    step();
    if_req_i = 1'b0;
    repeat (LAT + 1) step();
    chk("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);

    // Both ports read every cycle.
    nd = 0; nf = 0;
    if_req_i = 1'b1; if_addr_i = 32'h140;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h184;
    repeat (3 * (LAT + 1)) begin
      step();
      nd += int'(s_d_gnt);
      nf += int'(s_if_gnt);
    end
`ifdef MEM_ARB_RR_EN
    chk("t3_d_grants", 32'(nd), 32'd2);
    chk("t3_f_grants", 32'(nf), 32'd1);
`else
    chk("t3_d_grants", 32'(nd), 32'd3);
    chk("t3_f_grants", 32'(nf), 32'd0);
`endif
    if_req_i = 1'b0; d_req_i = 1'b0;
    repeat (LAT + 1) step();

    // Back-to-back partial writes, then read both words back.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'h12345678; d_be_i = 4'b0011;
    step();
    d_addr_i = 32'h204; d_wdata_i = 32'hCAFEF00D; d_be_i = 4'b1100;
    step();
    d_we_i = 1'b0; d_addr_i = 32'h200;
    step();
    d_req_i = 1'b0;
    repeat (LAT + 1) step();
    chk("t2_readback0", d_rdata_o, 32'hDEAD5678);
    d_req_i = 1'b1; d_addr_i = 32'h204;
    step();
    d_req_i = 1'b0;
    repeat (LAT + 1) step();
    chk("t2_readback1", d_rdata_o, 32'hCAFE1111);

    // Fetch raised during RD_WAIT is granted in the data rvalid cycle.
    d_req_i = 1'b1; d_addr_i = 32'h208;
    step();
    d_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h10C;
    repeat (LAT) step();
    step();
    chkb("t4_overlap", s_d_rvalid && s_if_gnt, 1'b1);
    if_req_i = 1'b0;
    repeat (LAT + 1) step();

    // Reset one cycle after a data read grant.
    d_req_i = 1'b1; d_addr_i = 32'h20C;
    step();
    d_req_i = 1'b0;
    rst = 1'b1;
    #2;
    chkb("t5_busy", busy_o, 1'b0);
    chk("t5_d_rdata", d_rdata_o, 32'h0);
    chk("t5_if_rdata", if_rdata_o, 32'h0);
    model_reset();
    rst = 1'b0;
    d_req_i = 1'b1; d_addr_i = 32'h210;
    step();
    chkb("t5_regrant", s_d_gnt, 1'b1);
    d_req_i = 1'b0;
    repeat (LAT + 1) step();

    // Fetch request withdrawn while a read is outstanding.
    d_req_i = 1'b1; d_addr_i = 32'h214;
    step();
    d_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h118;
    step();
    if_req_i = 1'b0;
    repeat (LAT + 1) step();

    // Random traffic: requests held until granted, occasionally withdrawn.
    for (int n = 0; n < 400; n++) begin
      step();
      if (g_if || (if_req_i && $urandom_range(7) == 0)) if_req_i = 1'b0;
      else if (!if_req_i && $urandom_range(2) == 0) begin
        if_req_i = 1'b1; if_addr_i = 32'($urandom_range(15)) << 2;
      end
      if (g_d || (d_req_i && $urandom_range(7) == 0)) d_req_i = 1'b0;
      else if (!d_req_i && $urandom_range(2) == 0) begin
        d_req_i   = 1'b1;
        d_we_i    = 1'($urandom_range(1));
        d_addr_i  = 32'($urandom_range(15)) << 2;
        d_wdata_i = $urandom;
        d_be_i    = 4'($urandom_range(15));
      end
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    repeat (LAT + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
